alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle instruction sequencer for the 8-bit fixed-point multiply-add ALU. It accepts one instruction at a time over a valid/ready handshake and drives the register-file read addresses. It then loads the ALU operand registers, waits a programmable settle time for the multiply/add path, and writes the ALU result back to the register file. It sits between the instruction source (program ROM or switch input) and the ALU/register-file pair.

## Interface
Parameters:
- BUS_WIDTH, 8, datapath width; must match the ALU.
- REG_ADDR_W, 3, register-file address width.
- EXEC_CYCLES, 1, settle cycles between operand load and write-back; legal range is 1 to 15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  sequencer can accept an instruction.
- instr_op  in  2  opcode.
- instr_rd, instr_ra, instr_rb  in  REG_ADDR_W  destination and source registers.
- instr_imm  in  BUS_WIDTH  immediate.
- rd_addr_a, rd_addr_b  out  REG_ADDR_W  register-file read addresses (feed ALU data_a, data_b).
- imm  out  BUS_WIDTH  immediate to ALU.
- reg_en  out  5  ALU operand-register enables, bits [0..4] = a, b, c, d, e.
- f_add, f_load  out  1  ALU operand-select controls.
- alu_result  in  BUS_WIDTH  ALU result.
- wr_en  out  1  register-file write strobe.
- wr_addr  out  REG_ADDR_W  register-file write address.
- result_q  out  BUS_WIDTH  last written-back value, for display.
- done  out  1  one-cycle pulse at write-back.
- halted  out  1  high after a HALT instruction.

## Operation
- Opcodes and their control settings:
  - 00 LDSW: f_add=0, f_load=0. The result is the switch value.
  - 01 MOV: f_add=0, f_load=1. The result is data_a.
  - 10 MAC: f_add=1, f_load=1. The ALU computes a·imm + c·imm + imm.
  - 11 HALT: no ALU activity.
- Accept: when instr_valid && instr_ready, latch op, rd, ra, rb and imm into an instruction register.
  - rd_addr_a, rd_addr_b, imm, f_add, f_load and wr_addr are driven from that register and stay stable until the next accept.
- FSM states: IDLE, LOAD, EXEC, WB, HALT.
  - IDLE: instr_ready=1. On accept of op≠11 go to LOAD; on accept of op=11 go to HALT.
  - LOAD: reg_en=5'b11111 for exactly one cycle, then EXEC. Load the counter with EXEC_CYCLES-1.
  - EXEC: reg_en=0. Count down; when the counter reaches 0, go to WB.
  - WB: wr_en=1, wr_addr=rd, done=1. Capture result_q <= alu_result, then go to IDLE.
  - HALT: halted=1, instr_ready=0. The block leaves HALT only on rst.
- instr_ready is a function of state only. It is 1 only in IDLE and never depends on instr_valid.
- instr_valid is ignored in every state except IDLE.
- The sequencer carries no data path. The write data path runs from the ALU to the register file directly; only result_q is copied.

## Timing
- Reset (rst=1 at an edge):
  - state becomes IDLE.
  - reg_en, wr_en, done, halted, f_add, f_load, imm, result_q and all address outputs become 0.
  - instr_ready is 0 while rst is high and 1 in the first cycle after.
- Reset during LOAD, EXEC or WB abandons the instruction. No wr_en is issued for it, and result_q keeps its reset value of 0.
- Latency, with the accept edge as cycle 0:
  - LOAD in cycle 1.
  - EXEC in cycles 2 to 1+EXEC_CYCLES.
  - WB in cycle 2+EXEC_CYCLES.
  - The next accept is possible at the end of cycle 3+EXEC_CYCLES.
- Throughput is one instruction per 3+EXEC_CYCLES cycles.
- No hazards: the previous instruction's write completes before the next instruction's operands load, including when rd equals the next ra.
- EXEC_CYCLES=1 gives exactly one EXEC cycle. The counter is 4 bits and never wraps, because it is reloaded on every LOAD.
- reg_en is never asserted in the same cycle as wr_en.

## Structure
- Shared package alu_ctrl_pkg holds:
  - opcode enum op_t: OP_LDSW, OP_MOV, OP_MAC, OP_HALT.
  - state enum state_t.
  - constant REG_EN_ALL = 5'b11111.
  - a per-opcode function returning {f_add, f_load}.
- No sub-module: the FSM, instruction register and settle counter sit in one module, 150–250 lines.

## Test plan
- Reset, then LDSW rd=3 with the ALU's sw input at 8'h2A, EXEC_CYCLES=1. Required: reg_en=11111 in cycle 1, wr_en with wr_addr=3 in cycle 3, result_q=8'h2A, done pulses once.
- MOV rd=5, ra=2 with register 2 holding 8'h11. Required: rd_addr_a=2 from cycle 1, f_load=1, f_add=0, wr_en with wr_addr=5, result_q=8'h11.
- Hold instr_valid high with four back-to-back LDSW instructions. Required: instr_ready low in LOAD, EXEC and WB; each instruction accepted exactly once; writes every 4 cycles.
- EXEC_CYCLES=3 with a MAC instruction. Required: reg_en=0 for 3 cycles after LOAD; wr_en in cycle 5; f_add=1 held throughout.
- Assert rst in the EXEC cycle. Required: no wr_en for that instruction, all outputs 0 on the next cycle, a new instruction accepted afterwards.
- Issue HALT, then more instructions with valid high. Required: halted=1, instr_ready stays 0, no reg_en or wr_en until rst clears it.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared opcode/state types and control decode for the ALU sequencer
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LDSW = 2'b00,
    OP_MOV  = 2'b01,
    OP_MAC  = 2'b10,
    OP_HALT = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_HALT = 3'd4
  } state_t;

  localparam logic [4:0] REG_EN_ALL = 5'b11111;

  // Returns {f_add, f_load}; HALT leaves the ALU idle.
  function automatic logic [1:0] op_flags(input op_t op);
    logic [1:0] w_flags;
    w_flags = 2'b00;
    case (op)
      OP_LDSW: w_flags = 2'b00;
      OP_MOV:  w_flags = 2'b01;
      OP_MAC:  w_flags = 2'b11;
      default: w_flags = 2'b00;
    endcase
    return w_flags;
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle instruction sequencer driving the multiply-add ALU and register file
module alu_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int BUS_WIDTH   = 8,
  parameter int REG_ADDR_W  = 3,
  parameter int EXEC_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [1:0]            instr_op,
  input  logic [REG_ADDR_W-1:0] instr_rd,
  input  logic [REG_ADDR_W-1:0] instr_ra,
  input  logic [REG_ADDR_W-1:0] instr_rb,
  input  logic [BUS_WIDTH-1:0]  instr_imm,
  output logic [REG_ADDR_W-1:0] rd_addr_a,
  output logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic [BUS_WIDTH-1:0]  imm,
  output logic [4:0]            reg_en,
  output logic                  f_add,
  output logic                  f_load,
  input  logic [BUS_WIDTH-1:0]  alu_result,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [BUS_WIDTH-1:0]  result_q,
  output logic                  done,
  output logic                  halted
);

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t                r_state;
  op_t                   r_op;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [REG_ADDR_W-1:0] r_ra;
  logic [REG_ADDR_W-1:0] r_rb;
  logic [BUS_WIDTH-1:0]  r_imm;
  logic [3:0]            r_cnt;
  logic [4:0]            r_reg_en;
  logic                  r_wr_en;
  logic                  r_done;
  logic                  r_halted;
  logic [BUS_WIDTH-1:0]  r_result;
  logic [1:0]            w_flags;

  // Ready must read low during reset even though the state register is still IDLE.
  assign instr_ready = (r_state == S_IDLE) && !rst;

  assign w_flags   = op_flags(r_op);
  assign f_add     = w_flags[1];
  assign f_load    = w_flags[0];
  assign rd_addr_a = r_ra;
  assign rd_addr_b = r_rb;
  assign imm       = r_imm;
  assign wr_addr   = r_rd;
  assign reg_en    = r_reg_en;
  assign wr_en     = r_wr_en;
  assign done      = r_done;
  assign halted    = r_halted;
  assign result_q  = r_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= OP_LDSW;
      r_rd     <= '0;
      r_ra     <= '0;
      r_rb     <= '0;
      r_imm    <= '0;
      r_cnt    <= '0;
      r_reg_en <= '0;
      r_wr_en  <= 1'b0;
      r_done   <= 1'b0;
      r_halted <= 1'b0;
      r_result <= '0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_op  <= op_t'(instr_op);
            r_rd  <= instr_rd;
            r_ra  <= instr_ra;
            r_rb  <= instr_rb;
            r_imm <= instr_imm;
            if (op_t'(instr_op) == OP_HALT) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else begin
              r_state  <= S_LOAD;
              r_reg_en <= REG_EN_ALL;
            end
          end
        end
        S_LOAD: begin
          r_reg_en <= '0;
          r_cnt    <= CNT_INIT;
          r_state  <= S_EXEC;
        end
        S_EXEC: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_WB;
            r_wr_en <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_WB: begin
          r_result <= alu_result;
          r_state  <= S_IDLE;
        end
        S_HALT: begin
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer with a behavioural ALU/register-file model
module tb_alu_sequencer;
  import alu_ctrl_pkg::*;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic mdl_init;

  // Instance 1: EXEC_CYCLES = 1
  logic       rst_1, instr_valid_1, instr_ready_1;
  logic [1:0] instr_op_1;
  logic [2:0] instr_rd_1, instr_ra_1, instr_rb_1;
  logic [7:0] instr_imm_1;
  logic [2:0] rd_addr_a_1, rd_addr_b_1, wr_addr_1;
  logic [7:0] imm_1, alu_result_1, result_q_1;
  logic [4:0] reg_en_1;
  logic       f_add_1, f_load_1, wr_en_1, done_1, halted_1;

  // Instance 3: EXEC_CYCLES = 3
  logic       rst_3, instr_valid_3, instr_ready_3;
  logic [1:0] instr_op_3;
  logic [2:0] instr_rd_3, instr_ra_3, instr_rb_3;
  logic [7:0] instr_imm_3;
  logic [2:0] rd_addr_a_3, rd_addr_b_3, wr_addr_3;
  logic [7:0] imm_3, alu_result_3, result_q_3;
  logic [4:0] reg_en_3;
  logic       f_add_3, f_load_3, wr_en_3, done_3, halted_3;

  alu_sequencer #(.BUS_WIDTH(8), .REG_ADDR_W(3), .EXEC_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst_1), .instr_valid(instr_valid_1), .instr_ready(instr_ready_1),
    .instr_op(instr_op_1), .instr_rd(instr_rd_1), .instr_ra(instr_ra_1), .instr_rb(instr_rb_1),
    .instr_imm(instr_imm_1), .rd_addr_a(rd_addr_a_1), .rd_addr_b(rd_addr_b_1), .imm(imm_1),
    .reg_en(reg_en_1), .f_add(f_add_1), .f_load(f_load_1), .alu_result(alu_result_1),
    .wr_en(wr_en_1), .wr_addr(wr_addr_1), .result_q(result_q_1), .done(done_1), .halted(halted_1)
  );

  alu_sequencer #(.BUS_WIDTH(8), .REG_ADDR_W(3), .EXEC_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst_3), .instr_valid(instr_valid_3), .instr_ready(instr_ready_3),
    .instr_op(instr_op_3), .instr_rd(instr_rd_3), .instr_ra(instr_ra_3), .instr_rb(instr_rb_3),
    .instr_imm(instr_imm_3), .rd_addr_a(rd_addr_a_3), .rd_addr_b(rd_addr_b_3), .imm(imm_3),
    .reg_en(reg_en_3), .f_add(f_add_3), .f_load(f_load_3), .alu_result(alu_result_3),
    .wr_en(wr_en_3), .wr_addr(wr_addr_3), .result_q(result_q_3), .done(done_3), .halted(halted_3)
  );

  // ALU + register-file models: operands captured on reg_en, write-back on wr_en.
  logic [7:0] rf1 [8];
  logic [7:0] rf3 [8];
  logic [7:0] a1, c1, im1, swl1, sw1;
  logic [7:0] a3, c3, im3, swl3, sw3;

  always @(posedge clk) begin
    if (mdl_init) begin
      for (int i = 0; i < 8; i++) begin
        rf1[i] <= 8'h00;
        rf3[i] <= 8'h00;
      end
      rf1[2] <= 8'h11;
      rf3[1] <= 8'h03;
      rf3[2] <= 8'h04;
    end else begin
      if (reg_en_1[0]) begin
        a1 <= rf1[rd_addr_a_1]; c1 <= rf1[rd_addr_b_1]; im1 <= imm_1; swl1 <= sw1;
      end
      if (wr_en_1) rf1[wr_addr_1] <= alu_result_1;
      if (reg_en_3[0]) begin
        a3 <= rf3[rd_addr_a_3]; c3 <= rf3[rd_addr_b_3]; im3 <= imm_3; swl3 <= sw3;
      end
      if (wr_en_3) rf3[wr_addr_3] <= alu_result_3;
    end
  end

  assign alu_result_1 = !f_load_1 ? swl1 : (!f_add_1 ? a1 : 8'(a1 * im1 + c1 * im1 + im1));
  assign alu_result_3 = !f_load_3 ? swl3 : (!f_add_3 ? a3 : 8'(a3 * im3 + c3 * im3 + im3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboards and monitors
  exp_t q1[$];
  exp_t q3[$];
  logic pend1 = 1'b0, pend3 = 1'b0;
  logic [7:0] pend1_d, pend3_d;
  int acc1 = 0;

  always @(negedge clk) begin
    exp_t e;
    if (pend1) begin
      chk("dut1_result_q", result_q_1, pend1_d);
      pend1 = 1'b0;
    end
    if (wr_en_1) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_write", {1'b1, wr_addr_1}, 4'h0);
      end else begin
        e = q1.pop_front();
        chk("dut1_wr_addr", wr_addr_1, e.addr);
        chk("dut1_wr_data", alu_result_1, e.data);
        chk("dut1_wb_done_noregen", {done_1, reg_en_1}, 6'b100000);
        pend1 = 1'b1;
        pend1_d = e.data;
      end
    end
    if (!rst_1 && instr_valid_1 && instr_ready_1) acc1++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (pend3) begin
      chk("dut3_result_q", result_q_3, pend3_d);
      pend3 = 1'b0;
    end
    if (wr_en_3) begin
      if (q3.size() == 0) begin
        chk("dut3_unexpected_write", {1'b1, wr_addr_3}, 4'h0);
      end else begin
        e = q3.pop_front();
        chk("dut3_wr_addr", wr_addr_3, e.addr);
        chk("dut3_wr_data", alu_result_3, e.data);
        pend3 = 1'b1;
        pend3_d = e.data;
      end
    end
  end

  task automatic issue1(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] ra,
                        input logic [2:0] rb, input logic [7:0] im);
    @(posedge clk); #1;
    instr_valid_1 = 1'b1; instr_op_1 = op; instr_rd_1 = rd;
    instr_ra_1 = ra; instr_rb_1 = rb; instr_imm_1 = im;
    @(posedge clk); #1;
    instr_valid_1 = 1'b0;
  endtask

  task automatic wait_ready1(output int n);
    n = 0;
    @(negedge clk);
    while (!instr_ready_1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!instr_ready_1) chk("ready_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int base;
    logic [2:0] rds [4];
    rds[0] = 3'd0; rds[1] = 3'd1; rds[2] = 3'd3; rds[3] = 3'd4;

    mdl_init = 1'b1;
    rst_1 = 1'b1; instr_valid_1 = 1'b0; instr_op_1 = 2'b00; instr_rd_1 = 3'd0;
    instr_ra_1 = 3'd0; instr_rb_1 = 3'd0; instr_imm_1 = 8'h00; sw1 = 8'h00;
    rst_3 = 1'b1; instr_valid_3 = 1'b0; instr_op_3 = 2'b00; instr_rd_3 = 3'd0;
    instr_ra_3 = 3'd0; instr_rb_3 = 3'd0; instr_imm_3 = 8'h00; sw3 = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready_low", instr_ready_1, 1'b0);
    chk("rst_outputs_zero", {reg_en_1, wr_en_1, done_1, halted_1, f_add_1, f_load_1,
                             imm_1, result_q_1, wr_addr_1, rd_addr_a_1, rd_addr_b_1}, 0);
    @(posedge clk); #1;
    rst_1 = 1'b0; rst_3 = 1'b0; mdl_init = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", instr_ready_1, 1'b1);

    // LDSW rd=3, switch 0x2A
    sw1 = 8'h2A;
    q1.push_back('{addr: 3'd3, data: 8'h2A});
    issue1(OP_LDSW, 3'd3, 3'd0, 3'd0, 8'h00);
    @(negedge clk);
    chk("ldsw_c1_reg_en", reg_en_1, 5'b11111);
    chk("ldsw_c1_ready", instr_ready_1, 1'b0);
    @(negedge clk);
    chk("ldsw_c2_regen_wren", {reg_en_1, wr_en_1}, 6'b0);
    @(negedge clk);
    chk("ldsw_c3_wb", {wr_en_1, done_1, wr_addr_1}, {1'b1, 1'b1, 3'd3});
    @(negedge clk);
    chk("ldsw_c4_done_once", {done_1, instr_ready_1}, 2'b01);

    // MOV rd=5, ra=2 (reg 2 holds 0x11)
    q1.push_back('{addr: 3'd5, data: 8'h11});
    issue1(OP_MOV, 3'd5, 3'd2, 3'd0, 8'h00);
    @(negedge clk);
    chk("mov_rd_addr_a", rd_addr_a_1, 3'd2);
    chk("mov_flags", {f_add_1, f_load_1}, 2'b01);
    repeat (3) @(negedge clk);

    // Four back-to-back LDSW with valid held high
    base = acc1;
    @(posedge clk); #1;
    instr_valid_1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instr_op_1 = OP_LDSW; instr_rd_1 = rds[i]; sw1 = 8'h40 + 8'(i);
      q1.push_back('{addr: rds[i], data: 8'h40 + 8'(i)});
      wait_ready1(w);
      chk("b2b_wait_cycles", w, (i == 0) ? 0 : 2);
      @(posedge clk); #1;
      @(negedge clk);
      chk("b2b_load_not_ready", {instr_ready_1, reg_en_1}, {1'b0, 5'b11111});
      @(posedge clk); #1;
    end
    instr_valid_1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_accept_count", acc1 - base, 4);

    // Reset during EXEC abandons the instruction
    sw1 = 8'h99;
    issue1(OP_LDSW, 3'd6, 3'd0, 3'd0, 8'h00);
    @(posedge clk); #1;
    rst_1 = 1'b1;
    @(posedge clk); #1;
    rst_1 = 1'b0;
    @(negedge clk);
    chk("abandon_outputs_zero", {reg_en_1, wr_en_1, done_1, halted_1, result_q_1,
                                 wr_addr_1, rd_addr_a_1, imm_1}, 0);
    chk("abandon_ready", instr_ready_1, 1'b1);
    q1.push_back('{addr: 3'd7, data: 8'h11});
    issue1(OP_MOV, 3'd7, 3'd5, 3'd0, 8'h00);
    repeat (4) @(negedge clk);

    // HALT, then valid held with more instructions
    base = acc1;
    issue1(OP_HALT, 3'd0, 3'd0, 3'd0, 8'h00);
    instr_valid_1 = 1'b1; instr_op_1 = OP_LDSW; instr_rd_1 = 3'd1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("halt_hold", {halted_1, instr_ready_1, reg_en_1, wr_en_1}, 8'h80);
    end
    chk("halt_accept_count", acc1 - base, 1);
    @(posedge clk); #1;
    rst_1 = 1'b1; instr_valid_1 = 1'b0;
    @(posedge clk); #1;
    rst_1 = 1'b0;
    @(negedge clk);
    chk("halt_cleared", {halted_1, instr_ready_1}, 2'b01);

    // EXEC_CYCLES=3, MAC rd=4 ra=1(3) rb=2(4) imm=5 -> 3*5+4*5+5 = 0x28
    q3.push_back('{addr: 3'd4, data: 8'h28});
    @(posedge clk); #1;
    instr_valid_3 = 1'b1; instr_op_3 = OP_MAC; instr_rd_3 = 3'd4;
    instr_ra_3 = 3'd1; instr_rb_3 = 3'd2; instr_imm_3 = 8'h05;
    @(posedge clk); #1;
    instr_valid_3 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("mac_f_add_held", f_add_3, 1'b1);
      if (k == 1) chk("mac_c1_reg_en", reg_en_3, 5'b11111);
      else if (k < 5) chk("mac_exec_idle", {reg_en_3, wr_en_3}, 6'b0);
      else chk("mac_c5_wr_en", {wr_en_3, reg_en_3}, {1'b1, 5'b0});
    end
    repeat (2) @(negedge clk);

    chk("dut1_scoreboard_empty", q1.size(), 0);
    chk("dut3_scoreboard_empty", q3.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
